// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher feeding decode.
// Issues word fetches on a req/gnt/rvalid bus, tags each returned word with
// its PC and PC+4, buffers it in a small FIFO and presents it valid/ready.
// A redirect restarts fetch at a new target, flushes the FIFO and discards
// every response that is still in flight.
module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [31:0]                if_instr,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Architectural state
  logic [31:0]   fetch_addr_reg, fetch_addr_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic [OW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [TW-1:0] tag_wr_reg, tag_wr_next;
  logic [TW-1:0] tag_rd_reg, tag_rd_next;

  // Storage: PC tags of granted requests, and the decode-facing FIFO
  logic [31:0] tag_mem   [MAX_OUTSTANDING];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  // Handshake decode
  logic [OW-1:0] live;
  logic [CW:0]   credit_sum;
  logic          has_room;
  logic          has_credit;
  logic          grant;
  logic          resp;
  logic          drop_now;
  logic          push;
  logic          pop;

  // Requests still destined for the FIFO reserve a slot, so a push can never overflow
  assign live       = outstanding_reg - drop_cnt_reg;
  assign credit_sum = {1'b0, count_reg} + (CW+1)'(live);
  assign has_room   = credit_sum < (CW+1)'(DEPTH);
  assign has_credit = outstanding_reg < OW'(MAX_OUTSTANDING);

  assign imem_req  = rst_n && !redirect && has_room && has_credit;
  assign imem_addr = fetch_addr_reg;

  assign grant    = imem_req && imem_gnt;
  assign resp     = imem_rvalid;
  assign drop_now = resp && (drop_cnt_reg != '0);
  // A redirect flushes the FIFO, so neither the returning word nor a decode pop lands
  assign push     = resp && !drop_now && !redirect;
  assign pop      = if_valid && if_ready && !redirect;

  assign if_valid    = (count_reg != '0);
  assign fq_count    = count_reg;
  assign if_instr    = instr_mem[rd_ptr_reg];
  assign if_pc       = pc_mem[rd_ptr_reg];
  assign if_pc_plus4 = if_pc + 32'd4;

  // Tag queue pointers wrap at MAX_OUTSTANDING, which need not be a power of two
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Next-state computation for fetch address, credits, drop accounting and FIFO
  always_comb begin
    fetch_addr_next  = fetch_addr_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    tag_wr_next      = tag_wr_reg;
    tag_rd_next      = tag_rd_reg;

    if (redirect) begin
      fetch_addr_next = redirect_pc & 32'hFFFF_FFFC;
    end else if (grant) begin
      fetch_addr_next = fetch_addr_reg + 32'd4;
    end

    if (grant && !resp) begin
      outstanding_next = outstanding_reg + OW'(1);
    end else if (resp && !grant) begin
      outstanding_next = outstanding_reg - OW'(1);
    end

    if (grant) begin
      tag_wr_next = tag_inc(tag_wr_reg);
    end
    if (resp) begin
      tag_rd_next = tag_inc(tag_rd_reg);
    end

    // Everything still in flight after this cycle's response is stale
    if (redirect) begin
      drop_cnt_next = resp ? (outstanding_reg - OW'(1)) : outstanding_reg;
    end else if (drop_now) begin
      drop_cnt_next = drop_cnt_reg - OW'(1);
    end

    if (redirect) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr_reg  <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      tag_wr_reg      <= '0;
      tag_rd_reg      <= '0;
    end else begin
      fetch_addr_reg  <= fetch_addr_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      tag_wr_reg      <= tag_wr_next;
      tag_rd_reg      <= tag_rd_next;
    end
  end

  // Storage writes: record the PC of each grant, and buffer accepted responses
  always_ff @(posedge clk) begin
    if (rst_n && grant) begin
      tag_mem[tag_wr_reg] <= fetch_addr_reg;
    end
    if (rst_n && push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= tag_mem[tag_rd_reg];
    end
  end

  // A response with nothing outstanding means the memory broke the protocol
  assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed tests with a scoreboard for fetch_queue.
// The test process pushes expected PCs; a monitor pops and compares on
// every accepted decode transfer. A small memory model answers fetches.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [2:0]  fq_count;

  // Second instance only observes its reset fetch address
  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_valid;
  logic [31:0] hi_instr;
  logic [31:0] hi_pc;
  logic [31:0] hi_pc_plus4;
  logic [2:0]  hi_count;

  fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .fq_count(fq_count)
  );

  fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_gnt(1'b0),
    .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .if_valid(hi_valid), .if_ready(1'b0), .if_instr(hi_instr),
    .if_pc(hi_pc), .if_pc_plus4(hi_pc_plus4), .fq_count(hi_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          grants = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] inflight_q[$];
  logic [31:0] exp_fetch = 32'h0;
  int          gnt_pct = 100;
  int          rv_pct = 100;
  bit          mem_hold = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pops < n && k < budget) begin
      sample();
      k++;
    end
    check(name, 32'(pops >= n), 32'd1);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    redirect = 1'b0;
    if_ready = 1'b0;
    tick();
    sample();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_fq_count", 32'(fq_count), 32'd0);
    check("rst_hi_req", 32'(hi_req), 32'd0);
    exp_pc_q.delete();
    pops = 0;
    grants = 0;
    exp_fetch = 32'h0;
    tick();
    rst_n = 1'b1;
  endtask

  // Memory model: grant bookkeeping on the edge, responses driven just after
  always begin : mem_model
    bit          g;
    bit          rs;
    logic [31:0] ga;
    @(negedge clk);
    g  = rst_n && imem_req && imem_gnt;
    ga = imem_addr;
    rs = rst_n;
    @(posedge clk);
    #1;
    if (!rs) begin
      inflight_q.delete();
    end else if (g) begin
      inflight_q.push_back(ga);
      grants++;
      check("fetch_addr", ga, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (rs && !mem_hold && inflight_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(inflight_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // Monitor: compare every accepted decode transfer against the scoreboard
  always @(negedge clk) begin : monitor
    logic [31:0] p;
    if (rst_n) begin
      check("fq_count_bound", 32'(fq_count <= 3'(DEPTH)), 32'd1);
      if (if_valid && if_ready && !redirect) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual_pc=%h required=none", if_pc);
        end else begin
          p = exp_pc_q.pop_front();
          check("if_pc", if_pc, p);
          check("if_pc_plus4", if_pc_plus4, p + 32'd4);
          check("if_instr", if_instr, mem_word(p));
        end
        pops++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int p0;
    // Test 1: streaming with a ready memory and ready decode
    gnt_pct = 100; rv_pct = 100; mem_hold = 1'b0;
    do_reset();
    if_ready = 1'b1;
    push_seq(32'h0, 64);
    sample();
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_valid_n", 32'(if_valid), 32'd0);
    sample();
    check("t1_valid_n1", 32'(if_valid), 32'd0);
    sample();
    check("t1_valid_n2", 32'(if_valid), 32'd1);
    p0 = pops;
    repeat (10) sample();
    check("t1_back_to_back", 32'(pops - p0), 32'd10);

    // Test 2: decode stalled, FIFO saturates, then drains in order
    do_reset();
    push_seq(32'h0, 64);
    repeat (12) sample();
    check("t2_grants", 32'(grants), 32'd4);
    check("t2_fq_full", 32'(fq_count), 32'd4);
    check("t2_req_low", 32'(imem_req), 32'd0);
    check("t2_head_pc", if_pc, 32'h0);
    tick();
    if_ready = 1'b1;
    repeat (4) sample();
    check("t2_pops", 32'(pops), 32'd4);

    // Test 3: redirect with two requests in flight drops both responses
    gnt_pct = 0; mem_hold = 1'b1;
    do_reset();
    if_ready = 1'b1;
    repeat (3) sample();
    check("t3_held_req", 32'(imem_req), 32'd1);
    check("t3_held_addr", imem_addr, 32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h10; exp_fetch = 32'h10;
    tick();
    redirect = 1'b0; gnt_pct = 100;
    repeat (6) sample();
    check("t3_grants", 32'(grants), 32'd2);
    check("t3_req_stalled", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h203; mem_hold = 1'b0;
    exp_fetch = 32'h200;
    exp_pc_q.delete();
    push_seq(32'h200, 64);
    sample();
    check("t3_req_in_redirect", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    sample();
    check("t3_new_addr", imem_addr, 32'h200);
    check("t3_fq_empty", 32'(fq_count), 32'd0);
    wait_pops(1, 20, "t3_first_pop");

    // Test 4: redirect coincides with a response and an attempted pop
    gnt_pct = 100; rv_pct = 100; mem_hold = 1'b0;
    do_reset();
    push_seq(32'h0, 8);
    repeat (10) sample();
    check("t4_fq_full", 32'(fq_count), 32'd4);
    tick();
    mem_hold = 1'b1; if_ready = 1'b1;
    tick();
    tick();
    if_ready = 1'b0;
    repeat (5) sample();
    check("t4_fq_two", 32'(fq_count), 32'd2);
    check("t4_pops_two", 32'(pops), 32'd2);
    check("t4_req_stalled", 32'(imem_req), 32'd0);
    check("t4_head_pc", if_pc, 32'h8);
    tick();
    mem_hold = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h300; if_ready = 1'b1;
    exp_fetch = 32'h300;
    exp_pc_q.delete();
    push_seq(32'h300, 64);
    p0 = pops;
    sample();
    check("t4_rvalid_same_cycle", 32'(imem_rvalid), 32'd1);
    check("t4_valid_same_cycle", 32'(if_valid), 32'd1);
    tick();
    redirect = 1'b0; if_ready = 1'b0;
    sample();
    check("t4_fq_cleared", 32'(fq_count), 32'd0);
    check("t4_valid_cleared", 32'(if_valid), 32'd0);
    check("t4_no_pop", 32'(pops), 32'(p0));
    tick();
    if_ready = 1'b1;
    wait_pops(p0 + 2, 30, "t4_refetch");

    // Test 5: address wrap at the top of the space, plus a high reset PC
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB; if_ready = 1'b1;
    exp_fetch = 32'hFFFF_FFF8;
    push_seq(32'hFFFF_FFF8, 64);
    sample();
    check("t5_hi_req", 32'(hi_req), 32'd1);
    check("t5_hi_addr", hi_addr, 32'hFFFF_FFF8);
    check("t5_hi_valid", 32'(hi_valid), 32'd0);
    tick();
    redirect = 1'b0;
    wait_pops(4, 30, "t5_wrap_pops");

    // Test 6: random memory delays and decode stalls, reset mid-stream
    gnt_pct = 60; rv_pct = 50;
    do_reset();
    push_seq(32'h0, 300);
    for (int i = 0; i < 150; i++) begin
      tick();
      if_ready = 1'($urandom_range(1));
    end
    do_reset();
    push_seq(32'h0, 300);
    for (int i = 0; i < 150; i++) begin
      tick();
      if_ready = 1'($urandom_range(1));
    end
    sample();
    check("t6_progress", 32'(pops >= 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
